pipe_ctrl: RTL and testbench

Central stall/flush controller for the six-stage pipeline (PC, IF, ID, EX, MEM, WB). It merges stall requests from ID, EX and MEM into the `stall[5:0]` vector that every pipeline register consumes. It converts MEM-stage exceptions into a one-cycle flush with a redirect PC. It also watches for hung memory-bus stalls. It sits beside the pipeline registers and is their only source of `stall`, `flush` and `new_pc`.

---
 rtl/pipe_ctrl.sv | 82 ++++++++
 tb/tb_pipe_ctrl.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the six-stage pipeline (PC, IF, ID, EX, MEM, WB)
//   clk, rst (sync, active-high)           : clock and reset
//   stallreq_id/ex/mem                     : stall requests, MEM has highest priority
//   excepttype, cp0_epc                    : MEM-stage exception code (0 = none, 0xE = ERET), EPC
//   stall[5:0] (bit0=PC .. bit5=WB), flush, new_pc, bus_timeout : control outputs
//   stall_cycles                           : saturating stall counter, only with PIPE_CTRL_PERF_EN
module pipe_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter logic [31:0] TMO_VECTOR     = 32'h0000_0040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout
`ifdef PIPE_CTRL_PERF_EN
  ,output logic [31:0] stall_cycles
`endif
);
  typedef enum logic [1:0] {RUN, RECOVER, TIMEOUT} state_t;
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  state_t      r_state, w_state_nx;
  logic [15:0] r_wd, w_wd_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_wd    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_wd    <= w_wd_nx;
    end
  end
  // wd only counts consecutive stalled RUN cycles; every other path leaves it cleared
  always_comb begin
    stall       = '0;
    flush       = 1'b0;
    new_pc      = '0;
    bus_timeout = 1'b0;
    w_state_nx  = r_state;
    w_wd_nx     = '0;
    if (!rst) begin
      case (r_state)
        RUN: begin
          if (excepttype != '0) begin
            flush      = 1'b1;
            new_pc     = (excepttype == 32'h0000_000E) ? cp0_epc : EXC_VECTOR;
            w_state_nx = RECOVER;
          end else begin
            stall = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
                    stallreq_id ? 6'b000111 : 6'b000000;
            if (stallreq_mem) begin
              if (r_wd == WD_LAST) w_state_nx = TIMEOUT;
              else w_wd_nx = r_wd + 16'd1;
            end
          end
        end
        TIMEOUT: begin
          flush       = 1'b1;
          new_pc      = TMO_VECTOR;
          bus_timeout = 1'b1;
          w_state_nx  = RECOVER;
        end
        default: w_state_nx = RUN;
      endcase
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  always_ff @(posedge clk) begin
    if (rst) r_stall_cycles <= '0;
    else if (|stall && ~&r_stall_cycles) r_stall_cycles <= r_stall_cycles + 32'd1;
  end
  assign stall_cycles = r_stall_cycles;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: vector table, corner sequences and randomized run against a reference model
module tb_pipe_ctrl;
  localparam int T = 4;
  logic        clk = 1'b0;
  logic        rst, id, ex, mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush, bto;
  logic [31:0] new_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
`endif
  int n_chk = 0, n_pass = 0;
  pipe_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .stallreq_id(id), .stallreq_ex(ex), .stallreq_mem(mem),
    .excepttype(exc), .cp0_epc(epc), .stall(stall), .flush(flush), .new_pc(new_pc),
    .bus_timeout(bto)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic r, i, e, m;
    logic [31:0] x, p;
    logic [5:0] st;
    logic fl;
    logic [31:0] pc;
    logic bt;
  } vec_t;
  vec_t vq[$];
  function automatic logic [39:0] pack(logic [5:0] s, logic f, logic [31:0] pc, logic b);
    return {s, f, pc, b};
  endfunction
  task automatic drive(input logic r, input logic i, input logic e, input logic m,
                       input logic [31:0] x, input logic [31:0] p);
    rst = r; id = i; ex = e; mem = m; exc = x; epc = p;
  endtask
  task automatic check(input string name, input logic [39:0] want);
    logic [39:0] got;
    @(negedge clk);
    got = pack(stall, flush, new_pc, bto);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s t=%0t got {stall,flush,new_pc,bto}=%h want %h", name, $time, got, want);
    @(posedge clk);
    #1;
  endtask
  task automatic step(input string name, input logic r, input logic i, input logic e,
                      input logic m, input logic [31:0] x, input logic [31:0] p,
                      input logic [39:0] want);
    drive(r, i, e, m, x, p);
    check(name, want);
  endtask
  int  m_streak;
  bit  m_tmo, m_bub;
  task automatic model(output logic [39:0] want);
    want = '0;
    if (rst) begin
      m_tmo = 0; m_bub = 0; m_streak = 0;
    end else if (m_tmo) begin
      want = pack(6'b0, 1'b1, 32'h40, 1'b1);
      m_tmo = 0; m_bub = 1; m_streak = 0;
    end else if (m_bub) begin
      m_bub = 0; m_streak = 0;
    end else if (exc != 0) begin
      want = pack(6'b0, 1'b1, (exc == 32'hE) ? epc : 32'h20, 1'b0);
      m_bub = 1; m_streak = 0;
    end else begin
      want = pack(mem ? 6'h1F : ex ? 6'h0F : id ? 6'h07 : 6'h00, 1'b0, 32'h0, 1'b0);
      m_streak = mem ? m_streak + 1 : 0;
      if (m_streak == T) begin
        m_tmo = 1; m_streak = 0;
      end
    end
  endtask
  initial begin
    logic [39:0] w;
    drive(1, 0, 0, 0, 0, 0);
    // r id ex mem exc epc | stall flush new_pc bto
    vq.push_back('{1,0,0,1,32'h8,0,        6'h00,0,32'h0,0});
    vq.push_back('{1,0,0,0,0,0,            6'h00,0,32'h0,0});
    vq.push_back('{0,1,0,0,0,0,            6'h07,0,32'h0,0});
    vq.push_back('{0,1,1,0,0,0,            6'h0F,0,32'h0,0});
    vq.push_back('{0,1,1,1,0,0,            6'h1F,0,32'h0,0});
    vq.push_back('{0,0,0,0,0,0,            6'h00,0,32'h0,0});
    vq.push_back('{0,0,0,1,32'h8,0,        6'h00,1,32'h20,0});
    vq.push_back('{0,0,1,0,32'h8,0,        6'h00,0,32'h0,0});
    vq.push_back('{0,0,1,0,0,0,            6'h0F,0,32'h0,0});
    vq.push_back('{0,0,0,0,32'hE,32'h1234, 6'h00,1,32'h1234,0});
    vq.push_back('{0,0,0,0,0,0,            6'h00,0,32'h0,0});
    for (int k = 0; k < T; k++) vq.push_back('{0,0,0,1,0,0, 6'h1F,0,32'h0,0});
    vq.push_back('{0,0,0,1,0,0,            6'h00,1,32'h40,1});
    vq.push_back('{0,0,0,1,0,0,            6'h00,0,32'h0,0});
    vq.push_back('{0,0,0,1,0,0,            6'h1F,0,32'h0,0});
    vq.push_back('{0,0,0,1,32'h4,0,        6'h00,1,32'h20,0});
    vq.push_back('{0,0,0,0,0,0,            6'h00,0,32'h0,0});
    for (int k = 0; k < T - 1; k++) vq.push_back('{0,0,0,1,0,0, 6'h1F,0,32'h0,0});
    vq.push_back('{0,0,0,1,32'h8,0,        6'h00,1,32'h20,0});
    vq.push_back('{0,0,0,1,0,0,            6'h00,0,32'h0,0});
    for (int k = 0; k < T; k++) vq.push_back('{0,0,0,1,0,0, 6'h1F,0,32'h0,0});
    vq.push_back('{0,0,0,1,0,0,            6'h00,1,32'h40,1});
    vq.push_back('{0,0,0,0,0,0,            6'h00,0,32'h0,0});
    @(posedge clk); #1;
    foreach (vq[k])
      step($sformatf("vec%0d", k), vq[k].r, vq[k].i, vq[k].e, vq[k].m, vq[k].x, vq[k].p,
           pack(vq[k].st, vq[k].fl, vq[k].pc, vq[k].bt));
    // reset during RECOVER, then a fresh watchdog count must need T full cycles
    step("rm_exc", 0, 0, 0, 1, 32'h8, 0, pack(6'h00, 1, 32'h20, 0));
    step("rm_rst", 1, 0, 1, 1, 32'h8, 0, pack(6'h00, 0, 32'h0, 0));
    step("rm_run", 0, 0, 0, 0, 0, 0, pack(6'h00, 0, 32'h0, 0));
    for (int k = 0; k < T; k++) step("rm_wd", 0, 0, 0, 1, 0, 0, pack(6'h1F, 0, 32'h0, 0));
    step("rm_tmo", 0, 0, 0, 1, 0, 0, pack(6'h00, 1, 32'h40, 1));
    step("rm_rec", 0, 0, 0, 0, 0, 0, pack(6'h00, 0, 32'h0, 0));
    // a one-cycle drop of stallreq_mem restarts the watchdog
    step("dr_a", 0, 0, 0, 1, 0, 0, pack(6'h1F, 0, 32'h0, 0));
    step("dr_b", 0, 0, 0, 1, 0, 0, pack(6'h1F, 0, 32'h0, 0));
    step("dr_0", 0, 1, 0, 0, 0, 0, pack(6'h07, 0, 32'h0, 0));
    for (int k = 0; k < T; k++) step("dr_wd", 0, 0, 0, 1, 0, 0, pack(6'h1F, 0, 32'h0, 0));
    step("dr_tmo", 0, 0, 0, 1, 0, 0, pack(6'h00, 1, 32'h40, 1));
    step("dr_rec", 0, 0, 0, 0, 0, 0, pack(6'h00, 0, 32'h0, 0));
`ifdef PIPE_CTRL_PERF_EN
    step("pf_rst", 1, 0, 0, 0, 0, 0, pack(6'h00, 0, 32'h0, 0));
    for (int k = 0; k < 10; k++) step("pf_id", 0, 1, 0, 0, 0, 0, pack(6'h07, 0, 32'h0, 0));
    for (int k = 0; k < 3; k++) step("pf_idle", 0, 0, 0, 0, 0, 0, pack(6'h00, 0, 32'h0, 0));
    n_chk++;
    if (stall_cycles === 32'd10) n_pass++;
    else $display("FAIL perf_cnt got %0d want 10", stall_cycles);
`endif
    drive(1, 0, 0, 0, 0, 0);
    model(w);
    check("rnd_rst", w);
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 63) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 7) != 0,
            ($urandom_range(0, 15) != 0) ? 32'h0 : ($urandom_range(0, 1) ? 32'hE : $urandom),
            $urandom);
      model(w);
      check($sformatf("rnd%0d", k), w);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
